// File: rtl/motor_speed_ctrl.sv
// Closed-loop PI speed controller: encoder count in, PWM out, with stall detection.
// One PI update runs per accepted sample through a short multi-cycle pipeline.
module motor_speed_ctrl #(
    parameter int PWM_PERIOD  = 1000,
    parameter int DUTY_W      = 10,
    parameter int KP          = 16,
    parameter int KI          = 2,
    parameter int SHIFT       = 8,
    parameter int INT_LIM     = 1048576,
    parameter int STALL_LIMIT = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en,
    input  logic [15:0]       target,
    input  logic [15:0]       meas,
    input  logic              meas_valid,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              sample_drop,
    output logic              fault
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    localparam logic signed [8:0]  KP_S    = {1'b0, 8'(KP)};
    localparam logic signed [8:0]  KI_S    = {1'b0, 8'(KI)};
    localparam logic signed [24:0] INT_HI  = 25'(INT_LIM - 1);
    localparam logic signed [24:0] INT_LO  = 25'(-INT_LIM);
    localparam logic signed [32:0] U_MAX   = 33'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0]  DUTY_MAX = DUTY_W'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0]  CNT_LAST = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [SW-1:0]      STALL_MAX = SW'(STALL_LIMIT);

    typedef enum logic [2:0] {IDLE, ERR, MUL, SUM, SAT} state_t;

    state_t                state;
    logic [15:0]           tgt_q;
    logic [15:0]           meas_q;
    logic signed [16:0]    err_q;
    logic signed [23:0]    integ;
    logic [SW-1:0]         stall_cnt;
    logic signed [24:0]    p_q;
    logic signed [31:0]    i_q;
    logic signed [32:0]    u_q;
    logic [DUTY_W-1:0]     duty_shadow;
    logic [DUTY_W-1:0]     pwm_cnt;

    logic signed [16:0]    err_c;
    logic signed [24:0]    integ_sum;
    logic signed [23:0]    integ_c;
    logic signed [32:0]    s_c;
    logic signed [32:0]    u_c;
    logic [DUTY_W-1:0]     sat_c;
    logic                  fault_set;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        err_c     = $signed({1'b0, tgt_q}) - $signed({1'b0, meas_q});
        integ_sum = 25'(integ) + 25'(err_c);
        integ_c   = integ_sum[23:0];
        if (integ_sum > INT_HI)
            integ_c = INT_HI[23:0];
        else if (integ_sum < INT_LO)
            integ_c = INT_LO[23:0];

        s_c = 33'(p_q) + 33'(i_q);
        u_c = s_c >>> SHIFT;

        sat_c = u_q[DUTY_W-1:0];
        if (u_q < 0)
            sat_c = '0;
        else if (u_q > U_MAX)
            sat_c = DUTY_MAX;

        fault_set = en && (state == SAT) && (stall_cnt == STALL_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            tgt_q       <= '0;
            meas_q      <= '0;
            err_q       <= '0;
            integ       <= '0;
            stall_cnt   <= '0;
            p_q         <= '0;
            i_q         <= '0;
            u_q         <= '0;
            duty_shadow <= '0;
            busy        <= 1'b0;
            sample_drop <= 1'b0;
            fault       <= 1'b0;
        end else if (!en) begin
            // Disable aborts any update in flight and clears all controller history.
            state       <= IDLE;
            integ       <= '0;
            stall_cnt   <= '0;
            duty_shadow <= '0;
            busy        <= 1'b0;
            sample_drop <= 1'b0;
            fault       <= 1'b0;
        end else begin
            sample_drop <= meas_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (meas_valid && !fault) begin
                        tgt_q  <= target;
                        meas_q <= meas;
                        state  <= ERR;
                    end
                end
                ERR: begin
                    err_q <= err_c;
                    integ <= integ_c;
                    if (tgt_q != 16'd0 && meas_q == 16'd0) begin
                        if (stall_cnt != STALL_MAX)
                            stall_cnt <= stall_cnt + 1'b1;
                    end else begin
                        stall_cnt <= '0;
                    end
                    busy  <= 1'b1;
                    state <= MUL;
                end
                MUL: begin
                    p_q   <= 25'(KP_S) * 25'(err_q);
                    i_q   <= 32'(KI_S) * 32'(integ);
                    state <= SUM;
                end
                SUM: begin
                    u_q   <= u_c;
                    state <= SAT;
                end
                SAT: begin
                    if (fault_set) begin
                        fault       <= 1'b1;
                        duty_shadow <= '0;
                    end else begin
                        duty_shadow <= sat_c;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // PWM: the active duty only changes at the period boundary, except forced off.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
            if (!en || fault || fault_set)
                duty <= '0;
            else if (pwm_cnt == CNT_LAST)
                duty <= duty_shadow;
            pwm_out <= (pwm_cnt < duty) && en && !fault;
        end
    end

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Self-checking bench for motor_speed_ctrl: directed scenarios plus randomized samples
// compared against an arithmetic model of the PI controller.
module tb_motor_speed_ctrl;

    localparam int PWM_PERIOD  = 1000;
    localparam int STALL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        n_rst, en, meas_valid;
    logic [15:0] target, meas;
    logic        pwm_out, busy, sample_drop, fault;
    logic [9:0]  duty;

    int errors = 0;
    int checks = 0;

    longint m_integ;
    int     m_stall;
    bit     m_fault;
    int     m_shadow;

    motor_speed_ctrl dut (
        .clk(clk), .n_rst(n_rst), .en(en), .target(target), .meas(meas),
        .meas_valid(meas_valid), .pwm_out(pwm_out), .duty(duty), .busy(busy),
        .sample_drop(sample_drop), .fault(fault)
    );

    always #10 clk = ~clk;

    function automatic longint floor_div256(longint s);
        if (s >= 0) return s / 256;
        return -((-s + 255) / 256);
    endfunction

    function automatic void model_sample(int t, int m);
        longint err, s, u;
        if (m_fault) return;
        err = t - m;
        m_integ = m_integ + err;
        if (m_integ > 1048575) m_integ = 1048575;
        if (m_integ < -1048576) m_integ = -1048576;
        if (t != 0 && m == 0) m_stall = (m_stall < STALL_LIMIT) ? m_stall + 1 : STALL_LIMIT;
        else m_stall = 0;
        s = 16 * err + 2 * m_integ;
        u = floor_div256(s);
        if (m_stall == STALL_LIMIT) begin
            m_fault  = 1'b1;
            m_shadow = 0;
        end else begin
            m_shadow = (u < 0) ? 0 : (u > PWM_PERIOD) ? PWM_PERIOD : int'(u);
        end
    endfunction

    function automatic void model_disable();
        m_integ = 0; m_stall = 0; m_fault = 1'b0; m_shadow = 0;
    endfunction

    function automatic int exp_duty();
        return m_fault ? 0 : m_shadow;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int t, input int m);
        target = 16'(t); meas = 16'(m); meas_valid = 1'b1;
        model_sample(t, m);
        tick();
        meas_valid = 1'b0;
        repeat (5) tick();
    endtask

    task automatic pulse_disable();
        en = 1'b0;
        tick();
        en = 1'b1;
        model_disable();
        tick();
    endtask

    task automatic wait_load();
        repeat (PWM_PERIOD + 2) tick();
    endtask

    task automatic settle_and_measure(output int d, output int highs);
        wait_load();
        d = int'(duty);
        highs = 0;
        for (int k = 0; k < PWM_PERIOD; k++) begin
            tick();
            highs += int'(pwm_out);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; en = 1'b0; meas_valid = 1'b0; target = '0; meas = '0;
        repeat (3) tick();
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        checks++; if (duty !== 10'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (sample_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", sample_drop); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        model_disable();
        n_rst = 1'b1; en = 1'b1;
        tick();
    endtask

    task automatic test_step();
        int d, h;
        bit exp_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        target = 16'd100; meas = 16'd0; meas_valid = 1'b1;
        model_sample(100, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            meas_valid = 1'b0;
            checks++;
            if (busy !== exp_busy[k]) begin
                errors++; $display("FAIL step_busy_T+%0d: got %b want %b", k, busy, exp_busy[k]);
            end
        end
        settle_and_measure(d, h);
        checks++; if (d !== exp_duty()) begin errors++; $display("FAIL step_duty: got %0d want %0d", d, exp_duty()); end
        checks++; if (h !== exp_duty()) begin errors++; $display("FAIL step_highs: got %0d want %0d", h, exp_duty()); end
    endtask

    task automatic test_negative();
        int d, h;
        pulse_disable();
        send(0, 50);
        settle_and_measure(d, h);
        checks++; if (d !== exp_duty()) begin errors++; $display("FAIL neg_duty: got %0d want %0d", d, exp_duty()); end
        checks++; if (h !== 0) begin errors++; $display("FAIL neg_highs: got %0d want 0", h); end
        // Integrator now -50; the next update exposes its value through the duty.
        send(200, 100);
        wait_load();
        checks++; if (int'(duty) !== exp_duty()) begin errors++; $display("FAIL neg_integ_duty: got %0d want %0d", duty, exp_duty()); end
    endtask

    task automatic test_saturation();
        int d, h;
        pulse_disable();
        send(40000, 0);
        settle_and_measure(d, h);
        checks++; if (d !== exp_duty()) begin errors++; $display("FAIL sat_duty: got %0d want %0d", d, exp_duty()); end
        checks++; if (h !== PWM_PERIOD) begin errors++; $display("FAIL sat_highs: got %0d want %0d", h, PWM_PERIOD); end
    endtask

    task automatic test_clamp();
        pulse_disable();
        repeat (27) send(40000, 1);
        wait_load();
        checks++; if (int'(duty) !== exp_duty()) begin errors++; $display("FAIL clamp_duty: got %0d want %0d", duty, exp_duty()); end
        // Walk the integrator down; the landing duty depends on where it was clamped.
        repeat (7) send(0, 65535);
        wait_load();
        checks++; if (int'(duty) !== exp_duty()) begin errors++; $display("FAIL clamp_walkdown: got %0d want %0d", duty, exp_duty()); end
    endtask

    task automatic test_stall_drop();
        int d, h;
        pulse_disable();
        repeat (4) send(100, 0);
        checks++; if (fault !== m_fault) begin errors++; $display("FAIL stall_fault: got %b want %b", fault, m_fault); end
        settle_and_measure(d, h);
        checks++; if (d !== exp_duty()) begin errors++; $display("FAIL stall_duty: got %0d want %0d", d, exp_duty()); end
        checks++; if (h !== 0) begin errors++; $display("FAIL stall_highs: got %0d want 0", h); end
        target = 16'd100; meas = 16'd0; meas_valid = 1'b1;
        model_sample(100, 0);
        tick();
        meas_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy !== 1'b0 || sample_drop !== 1'b0) begin
                errors++; $display("FAIL fault_ignore_%0d: got busy=%b drop=%b want 0/0", k, busy, sample_drop);
            end
            tick();
        end
        pulse_disable();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b want 0", fault); end
        send(100, 50);
        wait_load();
        checks++; if (int'(duty) !== exp_duty()) begin errors++; $display("FAIL integ_cleared: got %0d want %0d", duty, exp_duty()); end
        // Second meas_valid two cycles later must be dropped with a single pulse.
        target = 16'd100; meas = 16'd50; meas_valid = 1'b1;
        model_sample(100, 50);
        tick();
        meas_valid = 1'b0;
        checks++; if (sample_drop !== 1'b0) begin errors++; $display("FAIL drop_T: got %b want 0", sample_drop); end
        tick();
        meas_valid = 1'b1;
        checks++; if (sample_drop !== 1'b0) begin errors++; $display("FAIL drop_T+1: got %b want 0", sample_drop); end
        tick();
        meas_valid = 1'b0;
        checks++; if (sample_drop !== 1'b1) begin errors++; $display("FAIL drop_T+2: got %b want 1", sample_drop); end
        tick();
        checks++; if (sample_drop !== 1'b0) begin errors++; $display("FAIL drop_T+3: got %b want 0", sample_drop); end
        repeat (3) tick();
        send(100, 50);
        wait_load();
        checks++; if (int'(duty) !== exp_duty()) begin errors++; $display("FAIL drop_single_update: got %0d want %0d", duty, exp_duty()); end
    endtask

    task automatic test_mid_disable();
        int d, h;
        pulse_disable();
        target = 16'd100; meas = 16'd0; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        tick();
        en = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || duty !== 10'd0 || pwm_out !== 1'b0) begin
            errors++; $display("FAIL mid_disable: got busy=%b duty=%0d pwm=%b want 0/0/0", busy, duty, pwm_out);
        end
        en = 1'b1;
        model_disable();
        settle_and_measure(d, h);
        checks++; if (d !== 0 || h !== 0) begin errors++; $display("FAIL mid_disable_late: got duty=%0d highs=%0d want 0/0", d, h); end
        send(3000, 5);
        target = 16'd40000; meas = 16'd5; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        model_disable();
        checks++;
        if (busy !== 1'b0 || duty !== 10'd0 || fault !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got busy=%b duty=%0d fault=%b want 0/0/0", busy, duty, fault);
        end
        settle_and_measure(d, h);
        checks++; if (d !== 0 || h !== 0) begin errors++; $display("FAIL mid_reset_late: got duty=%0d highs=%0d want 0/0", d, h); end
    endtask

    task automatic test_random();
        int t, m;
        pulse_disable();
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                t = int'($urandom_range(200, 3000));
                m = t - 150 + int'($urandom_range(0, 300));
            end else begin
                t = int'($urandom_range(0, 65535));
                m = int'($urandom_range(1, 65535));
            end
            send(t, m);
            if (i % 2 == 1) begin
                wait_load();
                checks++;
                if (int'(duty) !== exp_duty()) begin
                    errors++; $display("FAIL rand_%0d (t=%0d m=%0d): got %0d want %0d", i, t, m, duty, exp_duty());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_negative();
        test_saturation();
        test_clamp();
        test_stall_drop();
        test_mid_disable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
